// File: rtl/m_table_pkg.sv
// Shared constants and FSM state type for the 1/m reciprocal table loader.
package m_table_pkg;

  localparam int unsigned BUFFER_DEPTH_DEF  = 2048;
  localparam int unsigned M_TABLE_WIDTH_DEF = 32;
  localparam int unsigned DIV_DVD_W_DEF     = M_TABLE_WIDTH_DEF + 2;
  localparam int unsigned DIV_QUO_W_DEF     = M_TABLE_WIDTH_DEF + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ZERO,
    ST_DIV,
    ST_WRITE,
    ST_FINISH
  } loader_state_e;

  // One quotient bit per cycle: a W-bit fraction needs W+1 steps.
  function automatic int unsigned div_cycles(input int unsigned w);
    return w + 1;
  endfunction

endpackage

// File: rtl/m_table_loader_if.sv
// Control and table-write bundle of the 1/m table loader.
interface m_table_loader_if
  import m_table_pkg::*;
#(
  parameter int unsigned AW = $clog2(BUFFER_DEPTH_DEF),
  parameter int unsigned DW = DIV_QUO_W_DEF
);
  logic          start_i;
  logic          wr_ready_i;
  logic          we_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic          busy_o;
  logic          done_o;

  modport master (
    input  start_i, wr_ready_i,
    output we_o, addr_o, data_o, busy_o, done_o
  );

  modport slave (
    output start_i, wr_ready_i,
    input  we_o, addr_o, data_o, busy_o, done_o
  );
endinterface

// File: rtl/m_recip_div.sv
// Restoring divider computing ceil(2^W / divisor), one quotient bit per cycle.
module m_recip_div
  import m_table_pkg::*;
#(
  parameter int unsigned W = M_TABLE_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W+1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W:0]   quotient
);

  localparam int unsigned DW = W + 2;
  localparam int unsigned RW = W + 1;
  localparam int unsigned CW = $clog2(div_cycles(W));

  logic [DW-1:0] dividend;
  logic [DW-1:0] div_q;
  logic [RW-1:0] rem_q;
  logic [W:0]    dvd_q;
  logic [W:0]    quo_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [DW-1:0] trial;
  logic          ge;

  always_comb begin
    dividend = (DW'(1) << W) + divisor - DW'(1);
    trial    = {rem_q, dvd_q[W]};
    ge       = (trial >= div_q);
    busy     = busy_q;
    done     = busy_q && (cnt_q == CW'(div_cycles(W) - 1));
    quotient = quo_q;
  end

  // The dividend MSB seeds the remainder; the remaining W+1 bits are shifted in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      div_q  <= divisor;
      rem_q  <= RW'(dividend[DW-1]);
      dvd_q  <= dividend[W:0];
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= ge ? RW'(trial - div_q) : RW'(trial);
      quo_q  <= {quo_q[W-1:0], ge};
      dvd_q  <= {dvd_q[W-1:0], 1'b0};
      cnt_q  <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/m_table_loader.sv
// Writes ceil(2^W/m) for every table entry m (entry 0 = 0) through a ready/strobe port.
// Define M_TABLE_LOADER_VERIFY_EN to add a per-quotient check with sticky err_o.
module m_table_loader
  import m_table_pkg::*;
#(
  parameter int unsigned BUFFER_DEPTH  = BUFFER_DEPTH_DEF,
  parameter int unsigned M_TABLE_WIDTH = M_TABLE_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic                            wr_ready_i,
  output logic                            we_o,
  output logic [$clog2(BUFFER_DEPTH)-1:0] addr_o,
  output logic [M_TABLE_WIDTH:0]          data_o,
  output logic                            busy_o,
  output logic                            done_o
`ifdef M_TABLE_LOADER_VERIFY_EN
  ,
  output logic                            err_o
`endif
);

  localparam int unsigned AW = $clog2(BUFFER_DEPTH);
  localparam int unsigned DW = M_TABLE_WIDTH + 2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(BUFFER_DEPTH - 1);

  loader_state_e        state_q, state_d;
  logic [AW-1:0]        addr_q;
  logic                 div_start;
  logic [DW-1:0]        div_divisor;
  logic                 div_busy;
  logic                 div_done;
  logic [M_TABLE_WIDTH:0] quotient;

  m_recip_div #(.W(M_TABLE_WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_ZERO;
      ST_ZERO:   if (wr_ready_i) state_d = ST_DIV;
      // An idle divider in DIV can only follow a lost start; leave rather than hang.
      ST_DIV:    if (div_done || !div_busy) state_d = ST_WRITE;
      ST_WRITE:  if (wr_ready_i) state_d = (addr_q == LAST_ADDR) ? ST_FINISH : ST_DIV;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    we_o        = (state_q == ST_ZERO) || (state_q == ST_WRITE);
    addr_o      = addr_q;
    data_o      = (state_q == ST_WRITE) ? quotient : '0;
    busy_o      = (state_q != ST_IDLE);
    done_o      = (state_q == ST_FINISH);
    div_start   = wr_ready_i && ((state_q == ST_ZERO) ||
                                 ((state_q == ST_WRITE) && (addr_q != LAST_ADDR)));
    div_divisor = DW'(addr_q) + DW'(1);
  end

  // Address advances together with the divider launch, so DIV already shows the next entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    addr_q <= '0;
    else if (state_q == ST_FINISH) addr_q <= '0;
    else if (div_start)            addr_q <= addr_q + AW'(1);
  end

`ifdef M_TABLE_LOADER_VERIFY_EN
  localparam int unsigned PW = M_TABLE_WIDTH + 1 + AW;

  logic [PW-1:0] two_w;
  logic [PW-1:0] prod;
  logic [PW-1:0] prod_less;
  logic          chk_bad;

  always_comb begin
    two_w     = PW'(1) << M_TABLE_WIDTH;
    prod      = PW'(quotient) * PW'(addr_q);
    prod_less = prod - PW'(addr_q);
    chk_bad   = (prod < two_w) || (prod_less >= two_w);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               err_o <= 1'b0;
    else if (start_i)                         err_o <= 1'b0;
    else if (state_q == ST_WRITE && chk_bad)  err_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_m_table_loader.sv
// Self-checking bench for m_table_loader against a cycle-level behavioural table model.
module tb_m_table_loader;
  import m_table_pkg::*;

  localparam int unsigned DEPTH = BUFFER_DEPTH_DEF;
  localparam int unsigned W     = M_TABLE_WIDTH_DEF;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  m_table_loader_if #(.AW(AW), .DW(W + 1)) bus ();
`ifdef M_TABLE_LOADER_VERIFY_EN
  logic err_o;
`endif

  m_table_loader #(.BUFFER_DEPTH(DEPTH), .M_TABLE_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (bus.start_i),
    .wr_ready_i (bus.wr_ready_i),
    .we_o       (bus.we_o),
    .addr_o     (bus.addr_o),
    .data_o     (bus.data_o),
    .busy_o     (bus.busy_o),
    .done_o     (bus.done_o)
`ifdef M_TABLE_LOADER_VERIFY_EN
    ,
    .err_o      (err_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ceil(2^W / m) by plain integer division plus round-up.
  function automatic longint unsigned recip(input int unsigned m);
    longint unsigned num, q;
    if (m == 0) return 0;
    num = 64'd1 << W;
    q   = num / m;
    if (q * m != num) q++;
    return q;
  endfunction

  // Model state (written only by the compare process)
  bit      active = 0;
  bit      done_exp = 0;
  int      wait_cnt = 0;
  int      nxt_addr = 0;
  int      dut_writes = 0;
  int      dut_dones = 0;
  longint  cycle = 0;
  longint unsigned seen [DEPTH];
  longint  wr_cyc [DEPTH];
  bit      corrupt_ok = 0;

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    bit exp_we;
    if (!rst_n) begin
      check("rst_we",   64'(bus.we_o),   64'd0);
      check("rst_addr", 64'(bus.addr_o), 64'd0);
      check("rst_data", 64'(bus.data_o), 64'd0);
      check("rst_busy", 64'(bus.busy_o), 64'd0);
      check("rst_done", 64'(bus.done_o), 64'd0);
      active = 0; done_exp = 0; wait_cnt = 0; nxt_addr = 0;
    end else begin
      exp_we = active && !done_exp && (wait_cnt == 0);
      check("we",   64'(bus.we_o),   64'(exp_we));
      check("busy", 64'(bus.busy_o), 64'(active));
      check("done", 64'(bus.done_o), 64'(done_exp));
      if (exp_we && bus.we_o) begin
        check("addr", 64'(bus.addr_o), 64'(nxt_addr));
        if (!corrupt_ok) check("data", 64'(bus.data_o), recip(nxt_addr));
      end
      if (bus.we_o && bus.wr_ready_i) begin
        dut_writes++;
        seen[bus.addr_o]   = 64'(bus.data_o);
        wr_cyc[bus.addr_o] = cycle;
      end
      if (bus.done_o) dut_dones++;
      if (done_exp) begin
        done_exp = 0;
        active   = 0;
      end else if (active) begin
        if (wait_cnt > 0) wait_cnt--;
        else if (bus.wr_ready_i) begin
          if (nxt_addr == int'(DEPTH - 1)) done_exp = 1;
          else begin
            nxt_addr++;
            wait_cnt = int'(W + 1);
          end
        end
      end else if (bus.start_i) begin
        active = 1; nxt_addr = 0; wait_cnt = 0;
      end
    end
  end

  task automatic pulse_start();
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  initial begin
    int base_w, base_d;
    bus.start_i = 1'b0;
    bus.wr_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("model_m1",    recip(1),    64'h1_0000_0000);
    check("model_m2047", recip(2047), 64'h200401);

    // Random backpressure load, aborted by reset at entry 100
    @(posedge clk); #1;
    pulse_start();
    for (int i = 0; i < 8000 && !(bus.we_o && bus.addr_o == AW'(100)); i++) begin
      bus.wr_ready_i = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    check("reach_entry100", 64'(bus.we_o && bus.addr_o == AW'(100)), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_we",   64'(bus.we_o),   64'd0);
    check("async_rst_addr", 64'(bus.addr_o), 64'd0);
    check("async_rst_data", 64'(bus.data_o), 64'd0);
    check("async_rst_busy", 64'(bus.busy_o), 64'd0);
    check("async_rst_done", 64'(bus.done_o), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Full load: ready high, 5-cycle stall at entry 5, stray start at entry 10
    bus.wr_ready_i = 1'b1;
    base_w = dut_writes;
    base_d = dut_dones;
    @(posedge clk); #1;
    pulse_start();
    check("restart_addr0", 64'(bus.addr_o), 64'd0);
    check("restart_we",    64'(bus.we_o),   64'd1);
    for (int i = 0; i < 1000 && !(bus.we_o && bus.addr_o == AW'(5)); i++) begin
      @(posedge clk); #1;
    end
    bus.wr_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_we",   64'(bus.we_o),   64'd1);
      check("bp_addr", 64'(bus.addr_o), 64'd5);
      check("bp_data", 64'(bus.data_o), 64'h3333_3334);
      @(posedge clk); #1;
    end
    bus.wr_ready_i = 1'b1;
    for (int i = 0; i < 1000 && !(bus.we_o && bus.addr_o == AW'(10)); i++) begin
      @(posedge clk); #1;
    end
    pulse_start();
    for (int i = 0; i < 80000 && !bus.done_o; i++) begin
      @(posedge clk); #1;
    end
    check("done_seen", 64'(bus.done_o), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check("write_count", 64'(dut_writes - base_w), 64'd2048);
    check("done_pulses", 64'(dut_dones - base_d),  64'd1);
    check("entry0",    seen[0],    64'd0);
    check("entry1",    seen[1],    64'h1_0000_0000);
    check("entry2",    seen[2],    64'h8000_0000);
    check("entry3",    seen[3],    64'h5555_5556);
    check("entry5",    seen[5],    64'h3333_3334);
    check("entry7",    seen[7],    64'h2492_4925);
    check("entry2047", seen[2047], 64'h200401);
    check("lat_0_to_1", 64'(wr_cyc[1] - wr_cyc[0]), 64'd34);
    check("lat_1_to_2", 64'(wr_cyc[2] - wr_cyc[1]), 64'd34);
    check("idle_after", 64'(bus.busy_o), 64'd0);

`ifdef M_TABLE_LOADER_VERIFY_EN
    pulse_start();
    check("err_clear", 64'(err_o), 64'd0);
    for (int i = 0; i < 2000 && !(bus.busy_o && !bus.we_o && bus.addr_o == AW'(9)); i++) begin
      @(posedge clk); #1;
    end
    corrupt_ok = 1;
    force dut.u_div.quotient = 33'h1;
    for (int i = 0; i < 200 && !bus.we_o; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 200 && bus.we_o; i++) begin
      @(posedge clk); #1;
    end
    release dut.u_div.quotient;
    corrupt_ok = 0;
    @(negedge clk);
    check("err_rise", 64'(err_o), 64'd1);
    repeat (100) @(posedge clk);
    #1;
    check("err_sticky", 64'(err_o), 64'd1);
    pulse_start();
    check("err_start_clr", 64'(err_o), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/m_table_loader.md
M_TABLE_LOADER -- requirements
Module: m_table_loader

Interface
REQ-001 SHALL have parameter BUFFER_DEPTH, default 2048: number of 1/m table entries; power of two.
REQ-002 SHALL have parameter M_TABLE_WIDTH, default 32: fraction width W of each reciprocal.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1: one-cycle pulse that begins a full table load.
REQ-007 SHALL have port wr_ready_i, input, 1: table accepts a write this cycle.
REQ-008 SHALL have port we_o, output, 1: write strobe to the table.
REQ-009 SHALL have port addr_o, output, $clog2(BUFFER_DEPTH): write address.
REQ-010 SHALL have port data_o, output, M_TABLE_WIDTH+1: reciprocal value.
REQ-011 SHALL have port busy_o, output, 1: load in progress.
REQ-012 SHALL have port done_o, output, 1: one-cycle pulse after the last write.

Function
REQ-013 SHALL produce entry m = ceil(2^W / m) for m = 1..BUFFER_DEPTH-1, e.g. m=1 gives 2^W (bit W set), m=2 gives 0x80000000.
REQ-014 SHALL write entry 0, the divide-by-zero slot, as all zeros.
REQ-015 SHALL use state machine IDLE -> ZERO -> DIV -> WRITE -> (DIV | FINISH) -> IDLE.
REQ-016 SHALL leave IDLE on start_i; start_i in any other state SHALL be ignored.
REQ-017 SHALL, in ZERO and WRITE, hold we_o=1 with stable addr_o/data_o until a cycle with wr_ready_i=1, then advance.
REQ-018 SHALL complete a write on the edge where we_o and wr_ready_i are both 1; there is no other write path.
REQ-019 SHALL compute each quotient in DIV with a restoring divider, one quotient bit per cycle, W+1 cycles; dividend 2^W + m - 1 (W+2 bits), divisor m (zero-extended).
REQ-020 SHALL take exactly W+2 cycles per entry for m ≥ 1 when wr_ready_i is held high.
REQ-021 SHALL go to FINISH after the write with addr_o = BUFFER_DEPTH-1 completes; address SHALL NOT wrap to 0.
REQ-022 SHALL assert done_o for exactly one cycle in FINISH, then return to IDLE.
REQ-023 SHALL hold busy_o=1 in every state except IDLE.
REQ-024 SHALL keep we_o=0 in IDLE, DIV and FINISH.

Reset
REQ-025 SHALL, when rst_n is low (any time, including mid-load), force state=IDLE, we_o=0, addr_o=0, data_o=0, busy_o=0, done_o=0, and clear divider state.
REQ-026 SHALL not resume an aborted load; a new start_i restarts from entry 0.

Configuration
REQ-027 SHALL support macro M_TABLE_LOADER_VERIFY_EN.
REQ-028 With M_TABLE_LOADER_VERIFY_EN defined, SHALL check each quotient q before its write: q*m ≥ 2^W and (q-1)*m < 2^W.
REQ-029 On a failed check SHALL set sticky output err_o; err_o SHALL clear only on reset or start_i.
REQ-030 Without M_TABLE_LOADER_VERIFY_EN, SHALL have no err_o port and no multiplier logic.

Structure
REQ-031 SHALL put the state enum typedef, default parameter values and divider width constants in shared package m_table_pkg.
REQ-032 SHALL implement the divider as sub-module m_recip_div, with ports start/divisor/busy/done/quotient.
REQ-033 SHALL be a drop-in writer for the existing 1/m table: the same addr/data widths, with the table's we/data_i fed from we_o/data_o.

Verification
REQ-034 Directed test, full load: reset, pulse start_i, wr_ready_i=1. Required: 2048 writes; entry 3=0x55555556, entry 7=0x24924925, entry 2047=0x200401, entry 0=0; done_o pulses once.
REQ-035 Directed test, latency: wr_ready_i=1. Required: entry 1 write W+2=34 cycles after the entry-0 write completes.
REQ-036 Directed test, backpressure: drop wr_ready_i for 5 cycles during the entry-5 write. Required: addr_o=5 and data_o=0x33333334 stable; no duplicate or skipped address.
REQ-037 Directed test, mid-load reset: assert rst_n low during entry 100. Required: all outputs 0 asynchronously; a fresh start_i rewrites from addr 0.
REQ-038 Directed test, start while busy: pulse start_i at entry 10. Required: no restart; exactly 2048 writes total.
REQ-039 Directed test, VERIFY_EN: force the divider quotient for entry 9 to the wrong value. Required: err_o rises and stays high until start_i.
